scalar_wb_arbiter: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 8-entry, 16-bit scalar register file. Two writeback sources share the file's single write port: the scalar ALU and the memory load unit. The arbiter grants one of them per cycle, round-robin on conflict, and drives a registered wr_en/wr_dst/wr_data triple into the register file. It also keeps a per-register busy bit, set at issue and cleared at writeback, which the decode stage uses for RAW/WAW stall decisions.

---
 rtl/scalar_wb_arbiter_if.sv | 37 +++
 rtl/scalar_wb_arbiter.sv | 71 +++++++
 tb/tb_scalar_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/scalar_wb_arbiter_if.sv
// Writeback bus between the ALU/load requesters, decode issue logic and the
// register file write-port arbiter.
interface scalar_wb_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    localparam int NREG = 2 ** ADDR_W;

    logic              alu_req;
    logic [ADDR_W-1:0] alu_dst;
    logic [DATA_W-1:0] alu_data;
    logic              alu_gnt;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_dst;
    logic [DATA_W-1:0] mem_data;
    logic              mem_gnt;
    logic              hold;
    logic              flush;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_dst;
    logic [NREG-1:0]   busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_dst;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output alu_req, alu_dst, alu_data, mem_req, mem_dst, mem_data,
               hold, flush, issue_en, issue_dst,
        input  alu_gnt, mem_gnt, busy, wr_en, wr_dst, wr_data
    );

    modport slave (
        input  alu_req, alu_dst, alu_data, mem_req, mem_dst, mem_data,
               hold, flush, issue_en, issue_dst,
        output alu_gnt, mem_gnt, busy, wr_en, wr_dst, wr_data
    );
endinterface

// File: rtl/scalar_wb_arbiter.sv
// Round-robin arbiter for the scalar register file write port, plus the
// per-register pending-write scoreboard used by decode for stall decisions.
module scalar_wb_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input logic               clk,
    input logic               rst,
    scalar_wb_arbiter_if.slave bus
);
    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MEM = 1'b1
    } prio_t;

    prio_t             prio;
    logic              blocked;
    logic              alu_win;
    logic              mem_win;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_dst_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_next;

    // prio only breaks ties; a lone requester always wins unless blocked.
    always_comb begin
        blocked = rst | bus.hold | bus.flush;
        alu_win = !blocked && bus.alu_req && (!bus.mem_req || prio == PRIO_ALU);
        mem_win = !blocked && bus.mem_req && (!bus.alu_req || prio == PRIO_MEM);
    end

    // Writeback clear is applied before issue set so a same-edge re-issue keeps the bit.
    always_comb begin
        busy_next = busy_q;
        if (wr_en_q) busy_next[wr_dst_q] = 1'b0;
        if (bus.issue_en) busy_next[bus.issue_dst] = 1'b1;
        if (bus.flush) busy_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio      <= PRIO_ALU;
            wr_en_q   <= 1'b0;
            wr_dst_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            busy_q  <= busy_next;
            wr_en_q <= alu_win | mem_win;
            if (alu_win) begin
                wr_dst_q  <= bus.alu_dst;
                wr_data_q <= bus.alu_data;
                prio      <= PRIO_MEM;
            end else if (mem_win) begin
                wr_dst_q  <= bus.mem_dst;
                wr_data_q <= bus.mem_data;
                prio      <= PRIO_ALU;
            end
        end
    end

    assign bus.alu_gnt = alu_win;
    assign bus.mem_gnt = mem_win;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_dst  = wr_dst_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Bench for scalar_wb_arbiter: directed scenarios followed by randomized
// traffic compared against a transaction-level model of grants and busy bits.
module tb_scalar_wb_arbiter;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    scalar_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

    scalar_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        bif.alu_req = 1'b0; bif.alu_dst = '0; bif.alu_data = '0;
        bif.mem_req = 1'b0; bif.mem_dst = '0; bif.mem_data = '0;
        bif.hold = 1'b0; bif.flush = 1'b0;
        bif.issue_en = 1'b0; bif.issue_dst = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bif.alu_req = 1'b1;
        bif.mem_req = 1'b1;
        @(negedge clk); #1;
        checks++; if (bif.alu_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_alu_gnt got=%b want=0", bif.alu_gnt); end
        checks++; if (bif.mem_gnt !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_gnt got=%b want=0", bif.mem_gnt); end
        checks++; if (bif.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_en got=%b want=0", bif.wr_en); end
        checks++; if (bif.wr_dst !== 3'd0) begin failures++; $display("[TB] FAIL reset_wr_dst got=%0d want=0", bif.wr_dst); end
        checks++; if (bif.wr_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_wr_data got=%h want=0000", bif.wr_data); end
        checks++; if (bif.busy !== 8'h00) begin failures++; $display("[TB] FAIL reset_busy got=%h want=00", bif.busy); end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bif.alu_req = 1'b1; bif.alu_dst = 3'd3; bif.alu_data = 16'hBEEF;
        #1;
        checks++; if (bif.alu_gnt !== 1'b1) begin failures++; $display("[TB] FAIL single_alu_gnt got=%b want=1", bif.alu_gnt); end
        checks++; if (bif.mem_gnt !== 1'b0) begin failures++; $display("[TB] FAIL single_mem_gnt got=%b want=0", bif.mem_gnt); end
        @(negedge clk);
        bif.alu_req = 1'b0;
        #1;
        checks++; if (bif.wr_en !== 1'b1) begin failures++; $display("[TB] FAIL single_wr_en got=%b want=1", bif.wr_en); end
        checks++; if (bif.wr_dst !== 3'd3) begin failures++; $display("[TB] FAIL single_wr_dst got=%0d want=3", bif.wr_dst); end
        checks++; if (bif.wr_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL single_wr_data got=%h want=beef", bif.wr_data); end
        @(negedge clk); #1;
        checks++; if (bif.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL single_wr_en_drop got=%b want=0", bif.wr_en); end
        checks++; if (bif.wr_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL single_wr_data_hold got=%h want=beef", bif.wr_data); end
    endtask

    task automatic test_contention();
        logic       exp_alu;
        logic [2:0] exp_dst;
        do_reset();
        @(negedge clk);
        bif.alu_req = 1'b1; bif.alu_dst = 3'd1; bif.alu_data = 16'hA1A1;
        bif.mem_req = 1'b1; bif.mem_dst = 3'd2; bif.mem_data = 16'hB2B2;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_alu = (k % 2 == 0);
            checks++; if (bif.alu_gnt !== exp_alu) begin failures++; $display("[TB] FAIL contend_alu_gnt[%0d] got=%b want=%b", k, bif.alu_gnt, exp_alu); end
            checks++; if (bif.mem_gnt !== !exp_alu) begin failures++; $display("[TB] FAIL contend_mem_gnt[%0d] got=%b want=%b", k, bif.mem_gnt, !exp_alu); end
            if (k > 0) begin
                exp_dst = (k % 2 == 1) ? 3'd1 : 3'd2;
                checks++; if (bif.wr_en !== 1'b1 || bif.wr_dst !== exp_dst) begin failures++; $display("[TB] FAIL contend_wr[%0d] got en=%b dst=%0d want en=1 dst=%0d", k, bif.wr_en, bif.wr_dst, exp_dst); end
            end
            @(negedge clk);
        end
        bif.alu_req = 1'b0;
        bif.mem_req = 1'b0;
        #1;
        checks++; if (bif.wr_en !== 1'b1 || bif.wr_dst !== 3'd2 || bif.wr_data !== 16'hB2B2) begin failures++; $display("[TB] FAIL contend_last_wr got en=%b dst=%0d data=%h want en=1 dst=2 data=b2b2", bif.wr_en, bif.wr_dst, bif.wr_data); end
        @(negedge clk); #1;
        checks++; if (bif.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL contend_idle_wr_en got=%b want=0", bif.wr_en); end
    endtask

    task automatic test_scoreboard();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            bif.issue_en = 1'b1; bif.issue_dst = 3'd5;
            @(negedge clk);
            bif.issue_en = 1'b0;
            bif.mem_req = 1'b1; bif.mem_dst = 3'd5; bif.mem_data = 16'h1234 + 16'(r);
            #1;
            checks++; if (bif.busy !== 8'h20) begin failures++; $display("[TB] FAIL sb_issue_busy[%0d] got=%h want=20", r, bif.busy); end
            checks++; if (bif.mem_gnt !== 1'b1) begin failures++; $display("[TB] FAIL sb_mem_gnt[%0d] got=%b want=1", r, bif.mem_gnt); end
            @(negedge clk);
            bif.mem_req = 1'b0;
            if (r == 1) begin
                bif.issue_en = 1'b1; bif.issue_dst = 3'd5;
            end
            #1;
            checks++; if (bif.wr_en !== 1'b1 || bif.wr_dst !== 3'd5) begin failures++; $display("[TB] FAIL sb_wr[%0d] got en=%b dst=%0d want en=1 dst=5", r, bif.wr_en, bif.wr_dst); end
            @(negedge clk);
            bif.issue_en = 1'b0;
            #1;
            if (r == 0) begin
                checks++; if (bif.busy !== 8'h00) begin failures++; $display("[TB] FAIL sb_clear_busy got=%h want=00", bif.busy); end
            end else begin
                checks++; if (bif.busy !== 8'h20) begin failures++; $display("[TB] FAIL sb_set_wins_busy got=%h want=20", bif.busy); end
            end
        end
    endtask

    task automatic test_hold_flush();
        // One lone ALU grant leaves MEM as the tie winner.
        @(negedge clk);
        bif.alu_req = 1'b1; bif.alu_dst = 3'd4; bif.alu_data = 16'h4444;
        #1;
        checks++; if (bif.alu_gnt !== 1'b1) begin failures++; $display("[TB] FAIL hold_pre_alu_gnt got=%b want=1", bif.alu_gnt); end
        @(negedge clk);
        bif.alu_dst = 3'd6; bif.alu_data = 16'h6666;
        bif.mem_req = 1'b1; bif.mem_dst = 3'd7; bif.mem_data = 16'h7777;
        bif.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bif.alu_gnt !== 1'b0 || bif.mem_gnt !== 1'b0) begin failures++; $display("[TB] FAIL hold_gnt[%0d] got alu=%b mem=%b want 0 0", i, bif.alu_gnt, bif.mem_gnt); end
            if (i > 0) begin
                checks++; if (bif.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL hold_wr_en[%0d] got=%b want=0", i, bif.wr_en); end
            end
            @(negedge clk);
        end
        bif.hold = 1'b0;
        #1;
        checks++; if (bif.mem_gnt !== 1'b1 || bif.alu_gnt !== 1'b0) begin failures++; $display("[TB] FAIL hold_release_prio got alu=%b mem=%b want alu=0 mem=1", bif.alu_gnt, bif.mem_gnt); end
        @(negedge clk);
        bif.mem_req = 1'b0;
        #1;
        checks++; if (bif.alu_gnt !== 1'b1) begin failures++; $display("[TB] FAIL hold_alu_after got=%b want=1", bif.alu_gnt); end
        @(negedge clk);
        bif.alu_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bif.issue_en = 1'b1; bif.issue_dst = 3'(i);
            @(negedge clk);
        end
        bif.issue_en = 1'b0;
        bif.flush = 1'b1;
        bif.alu_req = 1'b1; bif.alu_dst = 3'd0; bif.alu_data = 16'h0F0F;
        #1;
        checks++; if (bif.busy !== 8'hFF) begin failures++; $display("[TB] FAIL flush_pre_busy got=%h want=ff", bif.busy); end
        checks++; if (bif.alu_gnt !== 1'b0) begin failures++; $display("[TB] FAIL flush_alu_gnt got=%b want=0", bif.alu_gnt); end
        @(negedge clk);
        bif.flush = 1'b0;
        #1;
        checks++; if (bif.busy !== 8'h00) begin failures++; $display("[TB] FAIL flush_busy got=%h want=00", bif.busy); end
        checks++; if (bif.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL flush_wr_en got=%b want=0", bif.wr_en); end
        checks++; if (bif.alu_gnt !== 1'b1) begin failures++; $display("[TB] FAIL flush_resume_gnt got=%b want=1", bif.alu_gnt); end
        @(negedge clk);
        bif.alu_req = 1'b0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bif.issue_en = 1'b1; bif.issue_dst = 3'd2;
        bif.alu_req = 1'b1; bif.alu_dst = 3'd1; bif.alu_data = 16'hCAFE;
        @(posedge clk); #2;
        checks++; if (bif.wr_en !== 1'b1 || bif.busy[2] !== 1'b1) begin failures++; $display("[TB] FAIL arst_pre got en=%b busy=%h want en=1 busy[2]=1", bif.wr_en, bif.busy); end
        rst = 1'b1;
        #1;
        checks++; if (bif.wr_en !== 1'b0) begin failures++; $display("[TB] FAIL arst_wr_en got=%b want=0", bif.wr_en); end
        checks++; if (bif.wr_dst !== 3'd0 || bif.wr_data !== 16'h0000) begin failures++; $display("[TB] FAIL arst_wr got dst=%0d data=%h want 0 0000", bif.wr_dst, bif.wr_data); end
        checks++; if (bif.busy !== 8'h00) begin failures++; $display("[TB] FAIL arst_busy got=%h want=00", bif.busy); end
        checks++; if (bif.alu_gnt !== 1'b0) begin failures++; $display("[TB] FAIL arst_alu_gnt got=%b want=0", bif.alu_gnt); end
        @(negedge clk);
        rst = 1'b0;
        bif.issue_en = 1'b0;
        bif.mem_req = 1'b1; bif.mem_dst = 3'd2; bif.mem_data = 16'hD00D;
        #1;
        checks++; if (bif.alu_gnt !== 1'b1 || bif.mem_gnt !== 1'b0) begin failures++; $display("[TB] FAIL arst_tie got alu=%b mem=%b want alu=1 mem=0", bif.alu_gnt, bif.mem_gnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    // Transaction-level model: the tie goes to whoever did not win the last grant.
    task automatic test_random();
        bit          alu_pend, mem_pend, mem_won_last;
        logic [2:0]  a_dst, m_dst, exp_dst;
        logic [15:0] a_data, m_data, exp_data;
        logic [7:0]  exp_busy, clr_mask, set_mask;
        bit          exp_wr_en, go;
        int          winner;
        do_reset();
        alu_pend = 0; mem_pend = 0; mem_won_last = 1;
        a_dst = '0; m_dst = '0; a_data = '0; m_data = '0;
        exp_busy = 8'h00; exp_wr_en = 0; exp_dst = '0; exp_data = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!alu_pend && $urandom_range(0, 99) < 60) begin
                alu_pend = 1; a_dst = 3'($urandom); a_data = 16'($urandom);
            end
            if (!mem_pend && $urandom_range(0, 99) < 60) begin
                mem_pend = 1; m_dst = 3'($urandom); m_data = 16'($urandom);
            end
            bif.alu_req = alu_pend; bif.alu_dst = a_dst; bif.alu_data = a_data;
            bif.mem_req = mem_pend; bif.mem_dst = m_dst; bif.mem_data = m_data;
            bif.hold = ($urandom_range(0, 99) < 15);
            bif.flush = ($urandom_range(0, 99) < 5);
            bif.issue_en = ($urandom_range(0, 99) < 40);
            bif.issue_dst = 3'($urandom);
            #1;
            go = !bif.hold && !bif.flush;
            if (go && alu_pend && mem_pend) winner = mem_won_last ? 1 : 2;
            else if (go && alu_pend) winner = 1;
            else if (go && mem_pend) winner = 2;
            else winner = 0;
            checks++; if (bif.alu_gnt !== (winner == 1) || bif.mem_gnt !== (winner == 2)) begin failures++; $display("[TB] FAIL rand_gnt[%0d] got alu=%b mem=%b want alu=%b mem=%b", c, bif.alu_gnt, bif.mem_gnt, winner == 1, winner == 2); end
            checks++; if (bif.wr_en !== exp_wr_en || bif.wr_dst !== exp_dst || bif.wr_data !== exp_data) begin failures++; $display("[TB] FAIL rand_wr[%0d] got en=%b dst=%0d data=%h want en=%b dst=%0d data=%h", c, bif.wr_en, bif.wr_dst, bif.wr_data, exp_wr_en, exp_dst, exp_data); end
            checks++; if (bif.busy !== exp_busy) begin failures++; $display("[TB] FAIL rand_busy[%0d] got=%h want=%h", c, bif.busy, exp_busy); end
            clr_mask = exp_wr_en ? (8'h01 << exp_dst) : 8'h00;
            set_mask = bif.issue_en ? (8'h01 << bif.issue_dst) : 8'h00;
            exp_busy = bif.flush ? 8'h00 : ((exp_busy & ~clr_mask) | set_mask);
            exp_wr_en = (winner != 0);
            if (winner == 1) begin
                exp_dst = a_dst; exp_data = a_data; mem_won_last = 0; alu_pend = 0;
            end else if (winner == 2) begin
                exp_dst = m_dst; exp_data = m_data; mem_won_last = 1; mem_pend = 0;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_write();
        test_contention();
        test_scoreboard();
        test_hold_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
